// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage: owns the fetch PC, issues word reads under a credit limit,
// buffers returned words with their PCs for decode, and flushes on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic        fetch_misaligned
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = {1'b0, DEPTH_CNT};
  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [CW-1:0] out_cnt_r, out_cnt_s, cnt_r, cnt_s, drop_cnt_r, drop_cnt_s, inflight_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s, tag_rd_r, tag_rd_s, tag_wr_r, tag_wr_s;
  logic          dec_valid_r, misaligned_r, misaligned_s;
  logic [31:0]   buf_pc_r [BUF_DEPTH];
  logic [31:0]   buf_instr_r [BUF_DEPTH];
  logic [31:0]   tag_pc_r [BUF_DEPTH];
  logic [CW:0]   credit_s;
  logic          req_valid_s, accept_s, push_s, pop_s, rsp_hit_s;

  // Credit: words in flight plus words buffered never exceed the buffer size.
  assign credit_s    = {1'b0, out_cnt_r} + {1'b0, cnt_r};
  assign req_valid_s = (state_r == RUN) && !redirect_valid && (credit_s < DEPTH_EXT);
  assign accept_s    = req_valid_s && imem_req_ready;
  assign push_s      = imem_rsp_valid && (state_r == RUN) && !redirect_valid;
  assign pop_s       = dec_valid_r && dec_ready && !redirect_valid;
  assign inflight_s  = (state_r == DRAIN) ? drop_cnt_r : out_cnt_r;
  assign rsp_hit_s   = imem_rsp_valid && (inflight_s != CNT_ZERO);

  // Next-state and counter update; redirect overrides issue, response and pop.
  always_comb begin
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    out_cnt_s    = out_cnt_r;
    cnt_s        = cnt_r;
    drop_cnt_s   = drop_cnt_r;
    rd_ptr_s     = rd_ptr_r;
    wr_ptr_s     = wr_ptr_r;
    tag_rd_s     = tag_rd_r;
    tag_wr_s     = tag_wr_r;
    misaligned_s = misaligned_r;
    if (redirect_valid) begin
      cnt_s        = CNT_ZERO;
      out_cnt_s    = CNT_ZERO;
      rd_ptr_s     = PTR_ZERO;
      wr_ptr_s     = PTR_ZERO;
      tag_rd_s     = PTR_ZERO;
      tag_wr_s     = PTR_ZERO;
      drop_cnt_s   = inflight_s - (rsp_hit_s ? CNT_ONE : CNT_ZERO);
      fetch_pc_s   = {redirect_pc[31:2], 2'b00};
      misaligned_s = (redirect_pc[1:0] != 2'b00);
      state_s      = (drop_cnt_s != CNT_ZERO) ? DRAIN : RUN;
    end else begin
      cnt_s    = cnt_r + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
      rd_ptr_s = rd_ptr_r + (pop_s ? PTR_ONE : PTR_ZERO);
      case (state_r)
        BOOT: state_s = RUN;
        RUN: begin
          fetch_pc_s = accept_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
          tag_wr_s   = tag_wr_r + (accept_s ? PTR_ONE : PTR_ZERO);
          out_cnt_s  = out_cnt_r + (accept_s ? CNT_ONE : CNT_ZERO) - (push_s ? CNT_ONE : CNT_ZERO);
          wr_ptr_s   = wr_ptr_r + (push_s ? PTR_ONE : PTR_ZERO);
          tag_rd_s   = tag_rd_r + (push_s ? PTR_ONE : PTR_ZERO);
        end
        DRAIN: begin
          drop_cnt_s = drop_cnt_r - (rsp_hit_s ? CNT_ONE : CNT_ZERO);
          state_s    = (drop_cnt_s == CNT_ZERO) ? RUN : DRAIN;
        end
        default: state_s = BOOT;
      endcase
    end
  end

  // State, PC, counters and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= BOOT;
      fetch_pc_r   <= RESET_PC;
      out_cnt_r    <= CNT_ZERO;
      cnt_r        <= CNT_ZERO;
      drop_cnt_r   <= CNT_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      wr_ptr_r     <= PTR_ZERO;
      tag_rd_r     <= PTR_ZERO;
      tag_wr_r     <= PTR_ZERO;
      dec_valid_r  <= 1'b0;
      misaligned_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      fetch_pc_r   <= fetch_pc_s;
      out_cnt_r    <= out_cnt_s;
      cnt_r        <= cnt_s;
      drop_cnt_r   <= drop_cnt_s;
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      tag_rd_r     <= tag_rd_s;
      tag_wr_r     <= tag_wr_s;
      dec_valid_r  <= (cnt_s != CNT_ZERO);
      misaligned_r <= misaligned_s;
    end
  end

  // Instruction buffer and PC tag queue storage; cleared on reset so the
  // decode outputs read zero until the first word lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_r[i]    <= 32'h0;
        buf_instr_r[i] <= 32'h0;
        tag_pc_r[i]    <= 32'h0;
      end
    end else begin
      if (push_s) begin
        buf_pc_r[wr_ptr_r]    <= tag_pc_r[tag_rd_r];
        buf_instr_r[wr_ptr_r] <= imem_rsp_data;
      end
      if (accept_s) begin
        tag_pc_r[tag_wr_r] <= fetch_pc_r;
      end
    end
  end

  assign imem_req_valid   = req_valid_s;
  assign imem_req_addr    = fetch_pc_r;
  assign dec_valid        = dec_valid_r;
  assign dec_instr        = buf_instr_r[rd_ptr_r];
  assign dec_pc           = buf_pc_r[rd_ptr_r];
  assign fetch_misaligned = misaligned_r;

  // Overflow or a response with nothing in flight means the credit logic is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push_s && !pop_s && (cnt_r == DEPTH_CNT)))
    else $error("instr_fetch_unit: instruction buffer overflow");

  a_rsp_in_flight: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (inflight_s != CNT_ZERO))
    else $error("instr_fetch_unit: response with no read in flight");

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core. Owns the fetch PC, issues word reads to instruction memory over a valid/ready request port, and accepts in-order responses.
- Buffers fetched words with their PCs and presents {pc, instr} to decode and immediate generation over a valid/ready handshake.
- Handles branch/jump redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0040_0000, fetch PC loaded on reset
- BUF_DEPTH, 2, instruction buffer entries; also the cap on outstanding plus buffered words (power of 2, >=2)

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- imem_req_valid  output  1  read request valid
- imem_req_addr  output  32  word-aligned read address
- imem_req_ready  input  1  memory accepts request this cycle
- imem_rsp_valid  input  1  read data valid; responses return in request order, latency >=1 cycle
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  branch/jump taken, one-cycle pulse
- redirect_pc  input  32  new fetch target
- dec_valid  output  1  buffer head valid toward decode
- dec_instr  output  32  instruction at buffer head
- dec_pc  output  32  PC of dec_instr
- dec_ready  input  1  decode consumes head this cycle
- fetch_misaligned  output  1  sticky flag: last redirect target had bits[1:0] != 0

Behaviour:
- Reset (synchronous, active-high; wins over every other input):
  - fetch_pc = RESET_PC; buffer empty; outstanding = 0; drop_cnt = 0.
  - Outputs: dec_valid = 0, imem_req_valid = 0, fetch_misaligned = 0, dec_instr = 0, dec_pc = 0.
  - FSM enters BOOT.
- FSM states: BOOT, RUN, DRAIN.
  - BOOT: no request issued; next cycle goes to RUN.
  - RUN: normal fetching.
  - DRAIN: drop_cnt > 0; no new requests; every response decrements drop_cnt and is discarded. Goes to RUN in the cycle after drop_cnt reaches 0.
  - Redirect in any non-reset state: if responses are still in flight after accounting for any response arriving this cycle, go to DRAIN; otherwise go to RUN.
- Request issue:
  - imem_req_valid = (state == RUN) && !redirect_valid && (outstanding + count < BUF_DEPTH). This term is combinational.
  - imem_req_addr = fetch_pc.
  - On accept (req_valid && req_ready): fetch_pc += 4 (32-bit wrap from 32'hFFFF_FFFC to 0), outstanding += 1, and the issued address is pushed to an internal PC tag queue.
  - imem_req_valid stays asserted with a stable address until accepted.
- Response:
  - In RUN, a response writes {tag_pc, rsp_data} into the buffer tail and decrements outstanding.
  - Space is guaranteed by the credit rule, so overflow is impossible. A response that would overflow is a design error; assert it in simulation.
- Decode handshake:
  - dec_valid = (count != 0); dec_instr and dec_pc come from the buffer head.
  - A pop happens when dec_valid && dec_ready.
  - Push and pop in the same cycle: count is unchanged. A word arriving into an empty buffer is visible 1 cycle after imem_rsp_valid (registered buffer, no bypass).
  - Minimum latency from request accept to dec_valid = memory latency + 1.
- Redirect (redirect_valid = 1, higher priority than issue, response, and pop):
  - Buffer cleared; any pop that cycle is ignored; no request issued.
  - Tag queue is cleared. drop_cnt = outstanding minus the response arriving this cycle, if any (that response is discarded).
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - fetch_misaligned = (redirect_pc[1:0] != 0), held until the next redirect or reset.
  - dec_valid = 0 in the following cycle.
- Redirect while in DRAIN: drop_cnt is reloaded from the current in-flight count as above; the older target is lost.
- Reset mid-transaction: all counters clear. The memory is required to cancel in-flight reads on the same reset, so no response may arrive after reset.
- Widths: outstanding, count, and drop_cnt are clog2(BUF_DEPTH)+1 bits. No saturation is needed because the credit rule bounds them.

Test Plan:
- Reset release with 1-cycle memory, dec_ready = 1 → first imem_req_addr = 32'h0040_0000 in the cycle after BOOT, then 32'h0040_0004, 32'h0040_0008. dec_pc follows the same sequence, and dec_instr matches the memory image.
- Hold dec_ready = 0 for 6 cycles → at most 2 words buffered, imem_req_valid drops to 0, fetch_pc stops at 32'h0040_0008. Release dec_ready → fetching resumes with no lost or duplicated PC.
- 3-cycle memory latency, redirect to 32'h0040_0100 with 2 requests outstanding → state goes to DRAIN, both stale responses are discarded, and the next dec_pc is 32'h0040_0100.
- Redirect in the same cycle as a response and a dec pop → the response is dropped, the pop is ignored, and the buffer is empty the next cycle.
- Redirect to 32'h0040_0102 → imem_req_addr = 32'h0040_0100 and fetch_misaligned = 1. A later redirect to 32'h0040_0200 clears the flag.
- Assert reset mid-DRAIN → all outputs at their reset values the next cycle. After BOOT, fetch restarts at 32'h0040_0000.
